// File: rtl/uart_byte_tx.sv
// uart_byte_tx: parallel byte in, 8N1 UART frame out on a single pin.
// Optional even-parity bit between the data bits and the stop bit,
// enabled by defining UART_TX_PARITY_EN (default build: no parity, 10-bit frame).
//
// Handshake: a byte is taken on the rising clk edge where tx_valid && tx_ready.
// tx_ready is a flop that is high exactly while the FSM sits in IDLE; the
// producer must hold tx_data/tx_valid until that edge, and tx_valid while
// busy is simply not consumed (ready is low, so nothing is lost).
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  // A one-cycle bit period cannot be counted with this counter scheme.
  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_byte_tx: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
  } state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_done;
`ifdef UART_TX_PARITY_EN
  logic             parity;
`endif

  // Last cycle of the current serial bit.
  assign bit_done = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Busy is just the complement of the registered ready flop.
  assign tx_busy = ~tx_ready;

  // Frame sequencer: every output is registered so the line never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx_out   <= 1'b1;
      tx_ready <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          tx_out <= 1'b1;
          if (tx_valid && tx_ready) begin
            shreg    <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity   <= ^tx_data;
`endif
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_out   <= 1'b0;
            tx_ready <= 1'b0;
            state    <= S_START;
          end
        end

        S_START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            tx_out   <= shreg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            shreg    <= shreg >> 1;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              tx_out  <= parity;
              state   <= S_PARITY;
`else
              tx_out  <= 1'b1;
              state   <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_out  <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_done) begin
            baud_cnt <= '0;
            tx_out   <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
`endif

        S_STOP: begin
          // IDLE always gets at least one cycle with ready high, which is
          // why back-to-back frames see a stop bit one cycle longer.
          if (bit_done) begin
            baud_cnt <= '0;
            tx_ready <= 1'b1;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        default: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          tx_out   <= 1'b1;
          tx_ready <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
